// File: rtl/pio_irq_servicer_if.sv
// Avalon-MM link between the interrupt servicer (master) and a 6-bit
// edge-capturing PIO (slave), including the PIO's level interrupt.
interface pio_irq_servicer_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;

  modport master (
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata,
    input  pio_readdata,
    input  pio_irq
  );

  modport slave (
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata,
    output pio_readdata,
    output pio_irq
  );
endinterface

// File: rtl/pio_irq_servicer.sv
// Hardware ISR for an edge-capturing PIO: programs irq_mask, services pio_irq
// by reading/clearing edge_capture and sampling the level, and queues events.
module pio_irq_servicer #(
  parameter int               WIDTH     = 6,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] INIT_MASK = WIDTH'(6'h3F)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_irq_servicer_if.master   pio,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic                 cfg_mask_wr,
  output logic                 evt_valid,
  output logic [WIDTH-1:0]     evt_edges,
  output logic [WIDTH-1:0]     evt_level,
  input  logic                 evt_ready,
  output logic [7:0]           ovf_count,
  input  logic                 ovf_clr,
  output logic                 busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_CLR    = 3'd3,
    ST_RD_LVL = 3'd4,
    ST_PUSH   = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               init_wr_r;
  logic               cfg_pend_r;
  logic [WIDTH-1:0]   mask_r;
  logic [WIDTH-1:0]   cap_r;

  logic               cs_r;
  logic               wn_r;
  logic [1:0]         addr_r;
  logic [31:0]        wd_r;
  logic               cs_s;
  logic               wn_s;
  logic [1:0]         addr_s;
  logic [31:0]        wd_s;
  logic               busy_r;

  logic [WIDTH-1:0]   edges_mem_r [DEPTH];
  logic [WIDTH-1:0]   level_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               valid_r;
  logic [WIDTH-1:0]   head_edges_r;
  logic [WIDTH-1:0]   head_level_r;
  logic [7:0]         ovf_r;

  logic [WIDTH-1:0]   lvl_s;
  logic               do_pop_s;
  logic               push_req_s;
  logic               full_s;
  logic               do_push_s;
  logic               ovf_s;
  logic [PTR_W-1:0]   wr_ptr_s;
  logic [PTR_W-1:0]   rd_ptr_s;
  logic [CNT_W-1:0]   cnt_s;
  logic [WIDTH-1:0]   head_edges_s;
  logic [WIDTH-1:0]   head_level_s;

  assign lvl_s = pio.pio_readdata[WIDTH-1:0];

  // Next-state logic; INIT holds until its write has actually been driven on the bus
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_wr_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (cfg_pend_r) begin
          state_s = ST_INIT;
        end else if (pio.pio_irq) begin
          state_s = ST_RD_CAP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_CAP: state_s = ST_CLR;
      ST_CLR:    state_s = ST_RD_LVL;
      ST_RD_LVL: state_s = ST_PUSH;
      ST_PUSH:   state_s = ST_IDLE;
      default:   state_s = ST_INIT;
    endcase
  end

  // Bus access decode from the next state, so the registered access lines up with its state
  always_comb begin
    cs_s   = 1'b0;
    wn_s   = 1'b1;
    addr_s = 2'd0;
    wd_s   = 32'd0;
    case (state_s)
      ST_INIT: begin
        cs_s   = 1'b1;
        wn_s   = 1'b0;
        addr_s = 2'd2;
        wd_s   = 32'(mask_r);
      end
      ST_RD_CAP: begin
        cs_s   = 1'b1;
        addr_s = 2'd3;
      end
      ST_CLR: begin
        cs_s   = 1'b1;
        wn_s   = 1'b0;
        addr_s = 2'd3;
      end
      ST_RD_LVL: begin
        cs_s   = 1'b1;
        addr_s = 2'd0;
      end
      default: begin
        cs_s   = 1'b0;
      end
    endcase
  end

  // FSM state, bus output registers and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_INIT;
      init_wr_r <= 1'b0;
      cs_r      <= 1'b0;
      wn_r      <= 1'b1;
      addr_r    <= 2'd0;
      wd_r      <= 32'd0;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_s;
      init_wr_r <= (state_s == ST_INIT);
      cs_r      <= cs_s;
      wn_r      <= wn_s;
      addr_r    <= addr_s;
      wd_r      <= wd_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Mask shadow and pending flag; a new request wins over the clear on INIT entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r     <= INIT_MASK;
      cfg_pend_r <= 1'b0;
    end else begin
      if (cfg_mask_wr) begin
        mask_r     <= cfg_mask;
        cfg_pend_r <= 1'b1;
      end else if ((state_s == ST_INIT) && (state_r != ST_INIT)) begin
        cfg_pend_r <= 1'b0;
      end else begin
        cfg_pend_r <= cfg_pend_r;
      end
    end
  end

  // Captured edges, filtered by the mask in force during CLR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r <= '0;
    end else if (state_r == ST_CLR) begin
      cap_r <= lvl_s & mask_r;
    end else begin
      cap_r <= cap_r;
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle
  always_comb begin
    do_pop_s   = valid_r & evt_ready;
    push_req_s = (state_r == ST_PUSH) && (cap_r != '0);
    full_s     = (cnt_r == CNT_W'(DEPTH));
    do_push_s  = push_req_s && (!full_s || do_pop_s);
    ovf_s      = push_req_s && full_s && !do_pop_s;
    if (do_push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (do_pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_s = cnt_r - CNT_W'(1);
      default: cnt_s = cnt_r;
    endcase
  end

  // Next head value; forward the incoming event when it lands in the head slot
  always_comb begin
    head_edges_s = '0;
    head_level_s = '0;
    if (cnt_s == CNT_W'(0)) begin
      head_edges_s = '0;
      head_level_s = '0;
    end else if (do_push_s && (wr_ptr_r == rd_ptr_s)) begin
      head_edges_s = cap_r;
      head_level_s = lvl_s;
    end else begin
      head_edges_s = edges_mem_r[rd_ptr_s];
      head_level_s = level_mem_r[rd_ptr_s];
    end
  end

  // FIFO storage, pointers and registered head
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        edges_mem_r[i] <= '0;
        level_mem_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      cnt_r        <= '0;
      valid_r      <= 1'b0;
      head_edges_r <= '0;
      head_level_r <= '0;
    end else begin
      if (do_push_s) begin
        edges_mem_r[wr_ptr_r] <= cap_r;
        level_mem_r[wr_ptr_r] <= lvl_s;
      end
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      cnt_r        <= cnt_s;
      valid_r      <= (cnt_s != CNT_W'(0));
      head_edges_r <= head_edges_s;
      head_level_r <= head_level_s;
    end
  end

  // Saturating dropped-event counter; a same-cycle clear still records the new drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 8'd0;
    end else if (ovf_clr) begin
      ovf_r <= ovf_s ? 8'd1 : 8'd0;
    end else if (ovf_s && (ovf_r != 8'hFF)) begin
      ovf_r <= ovf_r + 8'd1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign pio.pio_address    = addr_r;
  assign pio.pio_chipselect = cs_r;
  assign pio.pio_write_n    = wn_r;
  assign pio.pio_writedata  = wd_r;
  assign evt_valid          = valid_r;
  assign evt_edges          = head_edges_r;
  assign evt_level          = head_level_r;
  assign ovf_count          = ovf_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Scoreboard bench: a behavioural edge-capturing PIO, queues of expected bus
// accesses and events, and negedge monitors that pop and compare them.
module tb_pio_irq_servicer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pio_irq_servicer_if pif();

  logic [5:0] cfg_mask = 6'h00;
  logic       cfg_mask_wr = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [5:0] evt_edges;
  logic [5:0] evt_level;
  logic [7:0] ovf_count;
  logic       busy;

  pio_irq_servicer #(.WIDTH(6), .DEPTH(4), .INIT_MASK(6'h3F)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pio         (pif),
    .cfg_mask    (cfg_mask),
    .cfg_mask_wr (cfg_mask_wr),
    .evt_valid   (evt_valid),
    .evt_edges   (evt_edges),
    .evt_level   (evt_level),
    .evt_ready   (evt_ready),
    .ovf_count   (ovf_count),
    .ovf_clr     (ovf_clr),
    .busy        (busy)
  );

  // Behavioural PIO: rising-edge capture, any write to 3 clears, registered readdata
  logic [5:0]  pins = 6'h00;
  logic [5:0]  pins_q = 6'h00;
  logic [5:0]  cap_m = 6'h00;
  logic [5:0]  mask_m = 6'h00;
  logic [31:0] rdata_m = 32'h0;

  always @(posedge clk) begin
    pins_q <= pins;
    if (pif.pio_chipselect && !pif.pio_write_n && pif.pio_address == 2'd3)
      cap_m <= pins & ~pins_q;
    else
      cap_m <= cap_m | (pins & ~pins_q);
    if (pif.pio_chipselect && !pif.pio_write_n && pif.pio_address == 2'd2)
      mask_m <= pif.pio_writedata[5:0];
    if (pif.pio_chipselect && pif.pio_write_n) begin
      case (pif.pio_address)
        2'd0:    rdata_m <= {26'd0, pins};
        2'd2:    rdata_m <= {26'd0, mask_m};
        2'd3:    rdata_m <= {26'd0, cap_m};
        default: rdata_m <= 32'd0;
      endcase
    end
  end
  assign pif.pio_readdata = rdata_m;
  assign pif.pio_irq      = |(cap_m & mask_m);

  typedef struct packed {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
  } bus_op_t;

  bus_op_t     exp_bus[$];
  logic [11:0] exp_evt[$];
  int checks = 0;
  int errors = 0;
  bus_op_t     mon_op;
  logic [11:0] mon_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_op(input logic we, input logic [1:0] addr, input logic [31:0] data);
    bus_op_t op;
    op.we = we;
    op.addr = addr;
    op.data = data;
    exp_bus.push_back(op);
  endtask

  // Monitors: every bus access and every popped event is matched against the queues
  always @(negedge clk) begin
    if (pif.pio_chipselect) begin
      if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got we=%0b addr=%0d data=0x%0h expected no access",
                 !pif.pio_write_n, pif.pio_address, pif.pio_writedata);
      end else begin
        mon_op = exp_bus.pop_front();
        chk("bus_we", {31'd0, !pif.pio_write_n}, {31'd0, mon_op.we});
        chk("bus_addr", {30'd0, pif.pio_address}, {30'd0, mon_op.addr});
        if (mon_op.we) chk("bus_wdata", pif.pio_writedata, mon_op.data);
      end
    end
    if (evt_valid && evt_ready) begin
      if (exp_evt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got edges=0x%0h level=0x%0h expected none", evt_edges, evt_level);
      end else begin
        mon_ev = exp_evt.pop_front();
        chk("evt_edges", {26'd0, evt_edges}, {26'd0, mon_ev[11:6]});
        chk("evt_level", {26'd0, evt_level}, {26'd0, mon_ev[5:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Change the pins and queue the expected service; optionally pop in PUSH or write cfg in RD_LVL
  task automatic set_pins(input logic [5:0] v, input bit svc, input logic [5:0] exp_edges,
                          input bit pop_at_push, input bit cfg_at_rdlvl, input logic [5:0] cfg_v);
    bit seen_rd0;
    bit pop_next;
    seen_rd0 = 1'b0;
    pop_next = 1'b0;
    step();
    pins = v;
    if (svc) begin
      exp_op(1'b0, 2'd3, 32'd0);
      exp_op(1'b1, 2'd3, 32'd0);
      exp_op(1'b0, 2'd0, 32'd0);
      if (cfg_at_rdlvl) exp_op(1'b1, 2'd2, {26'd0, cfg_v});
    end
    if (exp_edges != 6'h00) exp_evt.push_back({exp_edges, v});
    for (int i = 0; i < 14; i++) begin
      step();
      cfg_mask_wr = 1'b0;
      evt_ready = 1'b0;
      if (pop_next) begin
        evt_ready = 1'b1;
        pop_next = 1'b0;
      end
      if (pif.pio_chipselect && pif.pio_write_n && pif.pio_address == 2'd0) begin
        seen_rd0 = 1'b1;
        if (cfg_at_rdlvl) begin
          cfg_mask = cfg_v;
          cfg_mask_wr = 1'b1;
        end
        if (pop_at_push) pop_next = 1'b1;
      end
    end
    step();
    evt_ready = 1'b0;
    cfg_mask_wr = 1'b0;
    if (svc) chk("service_seen", {31'd0, seen_rd0}, 32'd1);
  endtask

  task automatic pop_n(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!evt_valid && t < 20) begin
        step();
        t++;
      end
      if (!evt_valid) begin
        checks++;
        errors++;
        $display("FAIL pop_timeout: got evt_valid=0 expected 1 within 20 cycles");
      end else begin
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int t;
    exp_op(1'b1, 2'd2, 32'h3F);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", {31'd0, pif.pio_chipselect}, 32'd0);
    chk("rst_write_n", {31'd0, pif.pio_write_n}, 32'd1);
    chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_ovf", {24'd0, ovf_count}, 32'd0);
    reset_n = 1'b1;
    repeat (5) step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_evt_valid", {31'd0, evt_valid}, 32'd0);

    // Single edge on bit 2
    set_pins(6'h04, 1'b1, 6'h04, 1'b0, 1'b0, 6'h00);
    chk("single_valid", {31'd0, evt_valid}, 32'd1);
    chk("single_edges", {26'd0, evt_edges}, 32'h04);
    chk("single_level", {26'd0, evt_level}, 32'h04);
    chk("irq_cleared", {31'd0, pif.pio_irq}, 32'd0);
    pop_n(1);
    chk("single_drained", {31'd0, evt_valid}, 32'd0);

    // Five events into a 4-deep FIFO: the fifth is dropped
    set_pins(6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    set_pins(6'h01, 1'b1, 6'h01, 1'b0, 1'b0, 6'h00);
    set_pins(6'h03, 1'b1, 6'h02, 1'b0, 1'b0, 6'h00);
    set_pins(6'h07, 1'b1, 6'h04, 1'b0, 1'b0, 6'h00);
    set_pins(6'h0F, 1'b1, 6'h08, 1'b0, 1'b0, 6'h00);
    set_pins(6'h1F, 1'b1, 6'h00, 1'b0, 1'b0, 6'h00);
    chk("ovf_after_5", {24'd0, ovf_count}, 32'd1);
    chk("full_head_edges", {26'd0, evt_edges}, 32'h01);

    // Full FIFO with push and pop in the same cycle
    set_pins(6'h3F, 1'b1, 6'h20, 1'b1, 1'b0, 6'h00);
    chk("coincide_ovf", {24'd0, ovf_count}, 32'd1);
    chk("coincide_head_edges", {26'd0, evt_edges}, 32'h02);
    chk("coincide_head_level", {26'd0, evt_level}, 32'h03);
    pop_n(4);
    chk("drain4_empty", {31'd0, evt_valid}, 32'd0);

    // Mask request during RD_LVL, then a masked edge produces nothing
    set_pins(6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    set_pins(6'h01, 1'b1, 6'h01, 1'b0, 1'b1, 6'h01);
    pop_n(1);
    set_pins(6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    set_pins(6'h08, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    chk("masked_no_evt", {31'd0, evt_valid}, 32'd0);
    set_pins(6'h09, 1'b1, 6'h01, 1'b0, 1'b0, 6'h00);
    set_pins(6'h08, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00);
    set_pins(6'h09, 1'b1, 6'h01, 1'b0, 1'b0, 6'h00);
    chk("two_queued", {31'd0, evt_valid}, 32'd1);
    set_pins(6'h08, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00);

    // Reset during CLR with two events queued
    step();
    pins = 6'h09;
    exp_op(1'b0, 2'd3, 32'd0);
    t = 0;
    while (!(pif.pio_chipselect && !pif.pio_write_n && pif.pio_address == 2'd3) && t < 12) begin
      step();
      t++;
    end
    chk("clr_reached", {31'd0, (t < 12)}, 32'd1);
    reset_n = 1'b0;
    exp_evt.delete();
    #1;
    chk("midrst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("midrst_ovf", {24'd0, ovf_count}, 32'd0);
    chk("midrst_cs", {31'd0, pif.pio_chipselect}, 32'd0);
    exp_op(1'b1, 2'd2, 32'h3F);
    exp_op(1'b0, 2'd3, 32'd0);
    exp_op(1'b1, 2'd3, 32'd0);
    exp_op(1'b0, 2'd0, 32'd0);
    exp_evt.push_back({6'h01, 6'h09});
    step();
    step();
    reset_n = 1'b1;
    repeat (16) step();
    pop_n(1);
    repeat (4) step();

    chk("bus_queue_empty", exp_bus.size(), 32'd0);
    chk("evt_queue_empty", exp_evt.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
- Hardware interrupt servicer for a 6-bit edge-capturing input PIO slave. The PIO has a 2-bit address, a 1-cycle registered readdata, an irq_mask register at address 2 and a write-to-clear edge_capture register at address 3.
- The block is the sole Avalon-MM master of the PIO. It writes the IRQ mask at start-up and on request.
- On pio_irq it reads edge_capture, clears it, samples the input level, and queues {edges, level} events in a small FIFO. The CPU or other logic drains the FIFO, so no software ISR is needed.

Parameters:
WIDTH, 6, PIO data width (1..32)
DEPTH, 4, event FIFO depth; power of 2, >=2
INIT_MASK, 6'h3F, irq_mask value written after reset

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
pio_address  out  2  PIO register address
pio_chipselect  out  1  PIO select
pio_write_n  out  1  PIO write strobe, active-low
pio_writedata  out  32  PIO write data; upper bits are zero
pio_readdata  in  32  PIO read data, valid 1 cycle after the address is presented
pio_irq  in  1  PIO interrupt, level
cfg_mask  in  WIDTH  new irq_mask value
cfg_mask_wr  in  1  1-cycle request to write cfg_mask
evt_valid  out  1  FIFO non-empty
evt_edges  out  WIDTH  head event: captured edge bits
evt_level  out  WIDTH  head event: input level after the clear
evt_ready  in  1  pop head when evt_valid&evt_ready
ovf_count  out  8  dropped-event count, saturating at 255
ovf_clr  in  1  zero ovf_count
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values (asynchronous): state=INIT; all pio_* outputs at 0 except pio_write_n=1; FIFO empty (evt_valid=0, evt_edges/evt_level=0); ovf_count=0; mask_reg=INIT_MASK; cfg_pend=0.
- Bus outputs are registered from state. Exactly one PIO access is made per cycle while chipselect=1. No access is made in IDLE.
- FSM, one cycle per state:
  - INIT: write addr 2, writedata=mask_reg. Next state IDLE.
  - IDLE: if cfg_pend, go to INIT. Else if pio_irq, go to RD_CAP. cfg has priority.
  - RD_CAP: read addr 3.
  - CLR: cap_reg<=pio_readdata[WIDTH-1:0]&mask_reg; write addr 3, writedata=0.
  - RD_LVL: read addr 0.
  - PUSH: lvl=pio_readdata[WIDTH-1:0]. If cap_reg!=0, push {cap_reg,lvl}. Next state IDLE.
- IRQ service latency: pio_irq rising in IDLE at cycle N puts the push in cycle N+4. The FSM is back in IDLE at N+5.
- pio_irq is already low by PUSH because the clear lands at the end of CLR. The FSM never re-enters RD_CAP on a stale irq.
- Edges arriving between RD_CAP and CLR are cleared by the PIO and lost. This is a documented limitation; no recovery is performed.
- cfg_mask_wr in any state: mask_reg<=cfg_mask and cfg_pend<=1. cfg_pend is cleared on INIT entry.
- A second cfg_mask_wr before INIT overwrites mask_reg; the last value wins.
- cap_reg masking uses mask_reg at CLR time.
- cap_reg==0 at PUSH (spurious or masked) produces no push and no overflow.
- FIFO is show-ahead: evt_edges/evt_level present the head while evt_valid=1.
- Push when full without a pop drops the event and increments ovf_count (saturating at 255).
- Push and pop in the same cycle when full: both occur, count is unchanged, no overflow.
- Pointers wrap modulo DEPTH.
- Pop when empty is ignored.
- ovf_clr and an overflow in the same cycle: ovf_count=1.
- Reset mid-operation aborts any transaction, empties the FIFO and re-runs INIT.

Test Plan:
- Reset release -> cycle 1 has chipselect=1, write_n=0, address=2, writedata=0x3F. Then IDLE with busy=0 and no bus activity.
- PIO edge on in_port[2], evt_ready=0 -> bus sequence rd3 / wr3 / rd0. evt_valid rises 4 cycles after irq with evt_edges=6'h04 and evt_level equal to the current pin value. pio_irq is 0 after the write.
- Five events with evt_ready=0 (DEPTH=4) -> 4 queued in order, ovf_count=1. Drain yields the events FIFO-ordered, then evt_valid=0.
- FIFO full, and a push and pop coincide -> count stays 4, ovf_count unchanged, head advances.
- cfg_mask_wr=1 with cfg_mask=6'h01 during RD_LVL -> the current service completes. INIT write of 0x01 occurs before any next RD_CAP. A later edge on bit 3 alone produces no event.
- Assert reset_n=0 in CLR with 2 events queued -> evt_valid=0 immediately, ovf_count=0. INIT write of 0x3F is repeated after release.
